// File: rtl/pmu_seq_ctrl_if.sv
// Handshake bundle between the digital control block and the PMU sequencer.
// The master side issues requests and trim writes. The slave side (the sequencer)
// drives the PMU analog control lines and the status flags.
interface pmu_seq_ctrl_if;
  logic       start;
  logic       shutdown;
  logic       trim_load;
  logic [3:0] trim_in;
  logic       DA_test1;
  logic       DA_test2;
  logic       DA_test3;
  logic [3:0] DA_test4;
  logic       busy;
  logic       ready;
  logic       err;

  modport master (
    output start, shutdown, trim_load, trim_in,
    input  DA_test1, DA_test2, DA_test3, DA_test4, busy, ready, err
  );

  modport slave (
    input  start, shutdown, trim_load, trim_in,
    output DA_test1, DA_test2, DA_test3, DA_test4, busy, ready, err
  );
endinterface

// File: rtl/pmu_seq_ctrl.sv
// PMU power-up/power-down sequencer.
// Turns start/shutdown levels into the ordered, minimum-width DA_test1..3 edge
// sequence and owns the DA_test4 trim register. Every output is a flop decoded
// from the state one cycle earlier, so inputs never reach the analog lines
// combinationally.
module pmu_seq_ctrl #(
  parameter int         PULSE1_CYC   = 1024,
  parameter int         GAP1_CYC     = 4,
  parameter int         GAP23_CYC    = 3,
  parameter logic [3:0] TRIM_DEFAULT = 4'h8,
  parameter int         CNT_W        = 16
) (
  input  logic              C_clk,
  input  logic              C_purstb,
  pmu_seq_ctrl_if.slave     bus
);

  typedef enum logic [2:0] {IDLE, P1, G1, EN2, ON, OFF3} state_t;

  // Counter preload values. A zero-length phase is stretched to one cycle.
  localparam logic [CNT_W-1:0] P1_LOAD  = (PULSE1_CYC > 0) ? CNT_W'(PULSE1_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] G1_LOAD  = (GAP1_CYC   > 0) ? CNT_W'(GAP1_CYC - 1)   : '0;
  localparam logic [CNT_W-1:0] G23_LOAD = (GAP23_CYC  > 0) ? CNT_W'(GAP23_CYC - 1)  : '0;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             sd_latch, sd_latch_next;
  logic [3:0]       trim;
  logic             da1, da2, da3, busy_q, ready_q, err_q;
  logic             da1_d, da2_d, da3_d, busy_d, ready_d;
  logic             trim_ok;
  logic             cnt_done;

  assign cnt_done = (cnt == '0);
  assign trim_ok  = (state == IDLE) || (state == ON);

  // State, phase counter and the P1 shutdown latch.
  always_ff @(posedge C_clk or negedge C_purstb) begin
    if (!C_purstb) begin
      state    <= IDLE;
      cnt      <= '0;
      sd_latch <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      sd_latch <= sd_latch_next;
    end
  end

  // Next-state logic. The kick pulse is never cut short: a shutdown during P1
  // is only remembered and acted on once the pulse has run its full length.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    sd_latch_next = sd_latch;
    case (state)
      IDLE: begin
        cnt_next      = '0;
        sd_latch_next = 1'b0;
        if (bus.start && !bus.shutdown) begin
          state_next = P1;
          cnt_next   = P1_LOAD;
        end
      end
      P1: begin
        if (bus.shutdown) sd_latch_next = 1'b1;
        if (cnt_done) begin
          sd_latch_next = 1'b0;
          if (sd_latch || bus.shutdown) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            state_next = G1;
            cnt_next   = G1_LOAD;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      G1: begin
        if (bus.shutdown) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_done) begin
          state_next = EN2;
          cnt_next   = G23_LOAD;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      EN2: begin
        if (bus.shutdown) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_done) begin
          state_next = ON;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      ON: begin
        if (bus.shutdown) begin
          state_next = OFF3;
          cnt_next   = G23_LOAD;
        end
      end
      OFF3: begin
        if (cnt_done) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next    = IDLE;
        cnt_next      = '0;
        sd_latch_next = 1'b0;
      end
    endcase
  end

  // Output decode from the current state. DA_test3 is released only while fully on.
  always_comb begin
    da1_d   = (state == P1);
    da2_d   = (state == EN2) || (state == ON) || (state == OFF3);
    da3_d   = (state != ON);
    busy_d  = (state == P1) || (state == G1) || (state == EN2) || (state == OFF3);
    ready_d = (state == ON);
  end

  // Output registers holding the analog lines and status flags.
  always_ff @(posedge C_clk or negedge C_purstb) begin
    if (!C_purstb) begin
      da1     <= 1'b0;
      da2     <= 1'b0;
      da3     <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      da1     <= da1_d;
      da2     <= da2_d;
      da3     <= da3_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  // Trim register. Writes in the middle of a sequence are dropped and flagged.
  always_ff @(posedge C_clk or negedge C_purstb) begin
    if (!C_purstb) begin
      trim  <= TRIM_DEFAULT;
      err_q <= 1'b0;
    end else begin
      if (bus.trim_load && trim_ok) trim <= bus.trim_in;
      err_q <= bus.trim_load && !trim_ok;
    end
  end

  assign bus.DA_test1 = da1;
  assign bus.DA_test2 = da2;
  assign bus.DA_test3 = da3;
  assign bus.DA_test4 = trim;
  assign bus.busy     = busy_q;
  assign bus.ready    = ready_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_pmu_seq_ctrl.sv
// Directed self-checking bench for pmu_seq_ctrl with hand-computed timing.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pmu_seq_ctrl;

  localparam int SIG_DA1   = 0;
  localparam int SIG_DA2   = 1;
  localparam int SIG_DA3   = 2;
  localparam int SIG_BUSY  = 3;
  localparam int SIG_READY = 4;
  localparam int SIG_ERR   = 5;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cnt;
  logic seen;

  pmu_seq_ctrl_if bus();

  pmu_seq_ctrl #(
    .PULSE1_CYC  (1024),
    .GAP1_CYC    (4),
    .GAP23_CYC   (3),
    .TRIM_DEFAULT(4'h8),
    .CNT_W       (16)
  ) dut (
    .C_clk   (clk),
    .C_purstb(rst_n),
    .bus     (bus)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic peek(input int which);
    case (which)
      SIG_DA1:   return bus.DA_test1;
      SIG_DA2:   return bus.DA_test2;
      SIG_DA3:   return bus.DA_test3;
      SIG_BUSY:  return bus.busy;
      SIG_READY: return bus.ready;
      default:   return bus.err;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic sd, input logic tl, input logic [3:0] ti);
    bus.start     = s;
    bus.shutdown  = sd;
    bus.trim_load = tl;
    bus.trim_in   = ti;
  endtask

  task automatic waitFor(input int which, input logic value, input int budget, input string tag);
    int   n;
    logic ok;
    n = 0;
    while (peek(which) !== value && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (peek(which) === value);
    checkOutput(tag, {15'd0, ok}, 16'd1);
  endtask

  task automatic countWhile(input int which, input logic value, input int budget, output int count);
    count = 0;
    while (peek(which) === value && count < budget) begin
      count++;
      @(negedge clk);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_da1"},   {15'd0, bus.DA_test1}, 16'd0);
    checkOutput({tag, "_da2"},   {15'd0, bus.DA_test2}, 16'd0);
    checkOutput({tag, "_da3"},   {15'd0, bus.DA_test3}, 16'd1);
    checkOutput({tag, "_da4"},   {12'd0, bus.DA_test4}, 16'h8);
    checkOutput({tag, "_busy"},  {15'd0, bus.busy},     16'd0);
    checkOutput({tag, "_ready"}, {15'd0, bus.ready},    16'd0);
    checkOutput({tag, "_err"},   {15'd0, bus.err},      16'd0);
  endtask

  task automatic startOnce();
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;

    // start and shutdown together: stay idle
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h0);
    repeat (3) @(negedge clk);
    checkOutput("both_high_busy", {15'd0, bus.busy}, 16'd0);
    checkOutput("both_high_da1", {15'd0, bus.DA_test1}, 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);

    // trim write in IDLE
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h3);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    checkOutput("trim_idle_da4", {12'd0, bus.DA_test4}, 16'h3);
    checkOutput("trim_idle_err", {15'd0, bus.err}, 16'd0);

    // rejected trim writes during P1, then shutdown latched in P1
    startOnce();
    waitFor(SIG_DA1, 1'b1, 5, "rej_p1_rise");
    applyStimulus(1'b0, 1'b0, 1'b1, 4'hF);
    @(negedge clk);
    checkOutput("rej_err1", {15'd0, bus.err}, 16'd1);
    checkOutput("rej_da4", {12'd0, bus.DA_test4}, 16'h3);
    @(negedge clk);
    checkOutput("rej_err_b2b", {15'd0, bus.err}, 16'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    checkOutput("rej_err_clear", {15'd0, bus.err}, 16'd0);
    checkOutput("rej_da4_hold", {12'd0, bus.DA_test4}, 16'h3);
    waitFor(SIG_BUSY, 1'b0, 1100, "rej_back_idle");
    checkOutput("rej_da2_low", {15'd0, bus.DA_test2}, 16'd0);

    // nominal power-up
    startOnce();
    checkOutput("pu_da1_not_early", {15'd0, bus.DA_test1}, 16'd0);
    @(negedge clk);
    checkOutput("pu_da1_rise", {15'd0, bus.DA_test1}, 16'd1);
    checkOutput("pu_busy", {15'd0, bus.busy}, 16'd1);
    countWhile(SIG_DA1, 1'b1, 2000, cnt);
    checkOutput("pu_p1_width", cnt[15:0], 16'd1024);
    countWhile(SIG_DA2, 1'b0, 100, cnt);
    checkOutput("pu_gap1", cnt[15:0], 16'd4);
    checkOutput("pu_en2_da3", {15'd0, bus.DA_test3}, 16'd1);
    countWhile(SIG_DA3, 1'b1, 100, cnt);
    checkOutput("pu_gap23", cnt[15:0], 16'd3);
    checkOutput("pu_ready", {15'd0, bus.ready}, 16'd1);
    checkOutput("pu_busy_off", {15'd0, bus.busy}, 16'd0);
    checkOutput("pu_da2_on", {15'd0, bus.DA_test2}, 16'd1);

    // trim write accepted in ON
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h5);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    checkOutput("trim_on_da4", {12'd0, bus.DA_test4}, 16'h5);
    checkOutput("trim_on_err", {15'd0, bus.err}, 16'd0);

    // power-down from ON
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    checkOutput("pd_da3", {15'd0, bus.DA_test3}, 16'd1);
    checkOutput("pd_ready", {15'd0, bus.ready}, 16'd0);
    checkOutput("pd_busy", {15'd0, bus.busy}, 16'd1);
    countWhile(SIG_DA2, 1'b1, 100, cnt);
    checkOutput("pd_da2_hold", cnt[15:0], 16'd3);
    checkOutput("pd_idle_busy", {15'd0, bus.busy}, 16'd0);
    checkOutput("pd_idle_da3", {15'd0, bus.DA_test3}, 16'd1);

    // abort in P1 at cycle 100: pulse still full length
    startOnce();
    waitFor(SIG_DA1, 1'b1, 5, "ab1_rise");
    cnt = 0;
    while (bus.DA_test1 === 1'b1 && cnt < 2000) begin
      cnt++;
      bus.shutdown = (cnt == 100);
      @(negedge clk);
    end
    bus.shutdown = 1'b0;
    checkOutput("ab1_p1_width", cnt[15:0], 16'd1024);
    seen = 1'b0;
    repeat (20) begin
      if (bus.DA_test2 === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    checkOutput("ab1_da2_never", {15'd0, seen}, 16'd0);
    checkOutput("ab1_busy", {15'd0, bus.busy}, 16'd0);

    // abort in EN2
    startOnce();
    waitFor(SIG_DA2, 1'b1, 1100, "ab2_en2");
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    checkOutput("ab2_da2", {15'd0, bus.DA_test2}, 16'd0);
    checkOutput("ab2_busy", {15'd0, bus.busy}, 16'd0);
    seen = 1'b0;
    repeat (6) begin
      if (bus.DA_test3 !== 1'b1 || bus.ready !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checkOutput("ab2_da3_stays", {15'd0, seen}, 16'd0);

    // asynchronous reset in EN2, then restart immediately
    startOnce();
    waitFor(SIG_DA2, 1'b1, 1100, "rst_en2");
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    startOnce();
    checkOutput("rst_da1_not_early", {15'd0, bus.DA_test1}, 16'd0);
    @(negedge clk);
    checkOutput("rst_da1_rise", {15'd0, bus.DA_test1}, 16'd1);
    countWhile(SIG_DA1, 1'b1, 2000, cnt);
    checkOutput("rst_p1_width", cnt[15:0], 16'd1024);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
